prbs_checker_16l: RTL and testbench

Receive-side PRBS checker for the 16-lane link. It takes the 16-bit word recovered by the RX deserializer, in which each lane carries one independent PRBS stream from the matching TX generator. Each lane self-synchronizes to its stream, tracks lock, and flags bit errors. Lane errors are summed into one saturating error counter for BER measurement.

---
 rtl/prbs_rx_pkg.sv | 12 +
 rtl/prbs_lane_checker.sv | 102 ++++++++++
 rtl/prbs_checker_16l.sv | 78 +++++++
 tb/tb_prbs_checker_16l.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_rx_pkg.sv
// Shared types and constants for the 16-lane receive-side PRBS checker.
package prbs_rx_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  localparam int          N_LANES          = 16;
  localparam logic [31:0] PRBS_EQN_DEFAULT = 32'h00100002;

endpackage

// File: rtl/prbs_lane_checker.sv
// One lane: self-synchronizing PRBS predictor with HUNT/LOCKED tracking and a
// registered per-sample error flag.
module prbs_lane_checker
  import prbs_rx_pkg::*;
#(
  parameter int n_prbs     = 32,
  parameter int lock_cnt   = 64,
  parameter int unlock_err = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cke,
  input  logic              din,
  input  logic [n_prbs-1:0] eqn,
  output logic              lock,
  output logic              err
);

  localparam int FILL_W  = $clog2(n_prbs + 1);
  localparam int MATCH_W = $clog2(lock_cnt + 1);
  localparam int CONS_W  = $clog2(unlock_err + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(n_prbs);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(lock_cnt);
  localparam logic [CONS_W-1:0]  CONS_LAST = CONS_W'(unlock_err - 1);

  logic [n_prbs-1:0]  h_q, h_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CONS_W-1:0]  cons_q, cons_d;
  lock_state_t        state_q, state_d;
  logic               err_q, err_d;
  logic               pred, valid, mismatch;

  always_comb begin
    h_d      = h_q;
    fill_d   = fill_q;
    match_d  = match_q;
    cons_d   = cons_q;
    state_d  = state_q;
    err_d    = 1'b0;
    pred     = ^(h_q & eqn);
    valid    = (fill_q == FILL_FULL);
    mismatch = valid && (din != pred);

    if (cke) begin
      h_d = {h_q[n_prbs-2:0], din};
      if (!valid) fill_d = fill_q + 1'b1;

      case (state_q)
        HUNT: begin
          if (mismatch) begin
            match_d = '0;
          end else if (valid) begin
            // Count saturates so an all-zero lane keeps waiting without wrapping.
            if (match_q != MATCH_MAX) match_d = match_q + 1'b1;
            if ((match_d == MATCH_MAX) && (h_d != '0)) begin
              state_d = LOCKED;
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          if (mismatch) begin
            err_d = 1'b1;
            if (cons_q == CONS_LAST) begin
              state_d = HUNT;
              match_d = '0;
              cons_d  = '0;
            end else begin
              cons_d = cons_q + 1'b1;
            end
          end else begin
            cons_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      cons_q  <= '0;
      state_q <= HUNT;
      err_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cons_q  <= cons_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign lock = (state_q == LOCKED);
  assign err  = err_q;

endmodule

// File: rtl/prbs_checker_16l.sv
// Multi-lane PRBS checker top: per-lane checkers, aggregate lock and a
// saturating error counter fed by the popcount of lane errors.
module prbs_checker_16l
  import prbs_rx_pkg::*;
#(
  parameter int n_prbs     = 32,
  parameter int n_lanes    = N_LANES,
  parameter int lock_cnt   = 64,
  parameter int unlock_err = 8,
  parameter int cnt_w      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cke,
  input  logic [n_lanes-1:0] din,
  input  logic [n_prbs-1:0]  eqn,
  input  logic               clr_err,
  output logic [n_lanes-1:0] lane_lock,
  output logic               all_lock,
  output logic [n_lanes-1:0] lane_err,
  output logic [cnt_w-1:0]   err_cnt
);

  localparam int SUM_W = $clog2(n_lanes + 1);

  logic [n_lanes-1:0] lock_w, err_w;
  logic [SUM_W-1:0]   inc;
  logic [cnt_w-1:0]   err_cnt_q, err_cnt_d;
  logic               all_lock_q, all_lock_d;

  function automatic logic [cnt_w-1:0] sat_add(input logic [cnt_w-1:0] a,
                                               input logic [SUM_W-1:0] b);
    logic [cnt_w:0] s;
    s = {1'b0, a} + (cnt_w + 1)'(b);
    if (s[cnt_w]) return '1;
    return s[cnt_w-1:0];
  endfunction

  for (genvar i = 0; i < n_lanes; i++) begin : g_lane
    prbs_lane_checker #(
      .n_prbs    (n_prbs),
      .lock_cnt  (lock_cnt),
      .unlock_err(unlock_err)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .cke (cke),
      .din (din[i]),
      .eqn (eqn),
      .lock(lock_w[i]),
      .err (err_w[i])
    );
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < n_lanes; i++) inc = inc + SUM_W'(err_w[i]);
    // A coincident clear discards this cycle's errors.
    err_cnt_d  = clr_err ? '0 : sat_add(err_cnt_q, inc);
    all_lock_d = &lock_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q  <= '0;
      all_lock_q <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      all_lock_q <= all_lock_d;
    end
  end

  assign lane_lock = lock_w;
  assign lane_err  = err_w;
  assign err_cnt   = err_cnt_q;
  assign all_lock  = all_lock_q;

endmodule

// File: tb/tb_prbs_checker_16l.sv
// Directed bench for prbs_checker_16l: lock, error multiplicity, unlock/relock,
// clear, saturation (4-bit counter instance), cke freeze and stuck-zero lane.
module tb_prbs_checker_16l;

  localparam logic [31:0] EQN = 32'h00100002;

  logic        clk = 1'b0;
  logic        rst, cke, clr_err;
  logic [15:0] din;
  logic [31:0] eqn;
  logic [15:0] lane_lock, lane_err, lane_lock4, lane_err4;
  logic        all_lock, all_lock4;
  logic [31:0] err_cnt;
  logic [3:0]  err_cnt4;

  int checks = 0;
  int errors = 0;

  logic [31:0] tx_h[16];
  logic [31:0] rx_h[16];

  prbs_checker_16l dut (
    .clk(clk), .rst(rst), .cke(cke), .din(din), .eqn(eqn), .clr_err(clr_err),
    .lane_lock(lane_lock), .all_lock(all_lock), .lane_err(lane_err), .err_cnt(err_cnt)
  );

  prbs_checker_16l #(.cnt_w(4)) dut4 (
    .clk(clk), .rst(rst), .cke(cke), .din(din), .eqn(eqn), .clr_err(clr_err),
    .lane_lock(lane_lock4), .all_lock(all_lock4), .lane_err(lane_err4), .err_cnt(err_cnt4)
  );

  always #5 clk = ~clk;

  task automatic seed_models();
    for (int i = 0; i < 16; i++) begin
      tx_h[i] = (i + 1) * 32'h9E3779B1;
      rx_h[i] = '0;
    end
  endtask

  // Drives one sample, then returns 1 time unit after the edge that takes it.
  task automatic drive(input logic [15:0] flip, input logic [15:0] zero,
                       input logic [15:0] inv_pred);
    logic [15:0] w;
    logic        b;
    w = '0;
    if (cke) begin
      for (int i = 0; i < 16; i++) begin
        b       = ^(tx_h[i] & EQN);
        tx_h[i] = {tx_h[i][30:0], b};
        w[i]    = b;
        if (inv_pred[i]) w[i] = ~(^(rx_h[i] & EQN));
        w[i] = w[i] ^ flip[i];
        if (zero[i]) w[i] = 1'b0;
      end
      for (int i = 0; i < 16; i++) rx_h[i] = {rx_h[i][30:0], w[i]};
    end else begin
      w = 16'($urandom);
    end
    din = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 16'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seed_models();
  endtask

  task automatic test_reset();
    rst = 1'b1; cke = 1'b1; clr_err = 1'b0; eqn = EQN;
    for (int k = 0; k < 3; k++) begin
      din = 16'($urandom);
      @(posedge clk);
    end
    #1;
    checks++; if (lane_lock !== 16'h0) begin errors++; $display("FAIL reset_lane_lock: got %h want 0000", lane_lock); end
    checks++; if (all_lock !== 1'b0) begin errors++; $display("FAIL reset_all_lock: got %b want 0", all_lock); end
    checks++; if (lane_err !== 16'h0) begin errors++; $display("FAIL reset_lane_err: got %h want 0000", lane_err); end
    checks++; if (err_cnt !== 32'h0) begin errors++; $display("FAIL reset_err_cnt: got %h want 0", err_cnt); end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      din = 16'($urandom);
      @(posedge clk);
      #1;
      checks++; if (lane_lock !== 16'h0) begin errors++; $display("FAIL reset_nolock cyc %0d: got %h want 0000", k, lane_lock); end
    end
  endtask

  task automatic test_clean_lock();
    bit bad;
    do_reset();
    for (int k = 0; k < 96; k++) begin
      drive(16'h0, 16'h0, 16'h0);
      if (k == 94) begin
        checks++; if (lane_lock !== 16'h0) begin errors++; $display("FAIL lock_early: got %h want 0000", lane_lock); end
      end
      if (k == 95) begin
        checks++; if (lane_lock !== 16'hFFFF) begin errors++; $display("FAIL lock_96: got %h want FFFF", lane_lock); end
        checks++; if (lane_lock4 !== 16'hFFFF) begin errors++; $display("FAIL lock4_96: got %h want FFFF", lane_lock4); end
        checks++; if (all_lock !== 1'b0) begin errors++; $display("FAIL all_lock_96: got %b want 0", all_lock); end
      end
    end
    drive(16'h0, 16'h0, 16'h0);
    checks++; if (all_lock !== 1'b1) begin errors++; $display("FAIL all_lock_97: got %b want 1", all_lock); end
    checks++; if (all_lock4 !== 1'b1) begin errors++; $display("FAIL all_lock4_97: got %b want 1", all_lock4); end
    bad = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      drive(16'h0, 16'h0, 16'h0);
      if (lane_err !== 16'h0 || err_cnt !== 32'h0 || lane_lock !== 16'hFFFF) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL clean_10k: err_cnt %h lane_lock %h want 0/FFFF", err_cnt, lane_lock); end
  endtask

  task automatic test_single_error();
    logic [15:0] exp;
    drive(16'h0020, 16'h0, 16'h0);
    checks++; if (lane_err !== 16'h0020) begin errors++; $display("FAIL single_err off 0: got %h want 0020", lane_err); end
    for (int k = 1; k <= 23; k++) begin
      drive(16'h0, 16'h0, 16'h0);
      exp = (k == 2 || k == 21) ? 16'h0020 : 16'h0000;
      checks++; if (lane_err !== exp) begin errors++; $display("FAIL single_err off %0d: got %h want %h", k, lane_err, exp); end
      if (k == 22) begin
        checks++; if (err_cnt !== 32'd3) begin errors++; $display("FAIL single_err_cnt: got %0d want 3", err_cnt); end
        checks++; if (err_cnt4 !== 4'd3) begin errors++; $display("FAIL single_err_cnt4: got %0d want 3", err_cnt4); end
      end
    end
    checks++; if (lane_lock !== 16'hFFFF) begin errors++; $display("FAIL single_err_lock: got %h want FFFF", lane_lock); end
  endtask

  task automatic test_unlock_relock();
    int n;
    for (int k = 1; k <= 8; k++) begin
      drive(16'h0, 16'h0, 16'h0004);
      checks++; if (lane_err !== 16'h0004) begin errors++; $display("FAIL unlock_err %0d: got %h want 0004", k, lane_err); end
      if (k == 7) begin
        checks++; if (lane_lock !== 16'hFFFF) begin errors++; $display("FAIL unlock_early: got %h want FFFF", lane_lock); end
      end
      if (k == 8) begin
        checks++; if (lane_lock !== 16'hFFFB) begin errors++; $display("FAIL unlock_8: got %h want FFFB", lane_lock); end
      end
    end
    drive(16'h0, 16'h0, 16'h0);
    checks++; if (err_cnt !== 32'd11) begin errors++; $display("FAIL unlock_cnt: got %0d want 11", err_cnt); end
    n = 0;
    while (lane_lock !== 16'hFFFF && n < 96) begin
      drive(16'h0, 16'h0, 16'h0);
      n++;
    end
    checks++; if (lane_lock !== 16'hFFFF) begin errors++; $display("FAIL relock: got %h want FFFF after %0d samples", lane_lock, n); end
    repeat (5) drive(16'h0, 16'h0, 16'h0);
    checks++; if (err_cnt !== 32'd11) begin errors++; $display("FAIL relock_cnt: got %0d want 11", err_cnt); end
    checks++; if (all_lock !== 1'b1) begin errors++; $display("FAIL relock_all: got %b want 1", all_lock); end
  endtask

  task automatic test_clear();
    drive(16'h0001, 16'h0, 16'h0);
    checks++; if (lane_err !== 16'h0001) begin errors++; $display("FAIL clear_pulse: got %h want 0001", lane_err); end
    clr_err = 1'b1;
    drive(16'h0, 16'h0, 16'h0);
    clr_err = 1'b0;
    checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL clear_wins: got %0d want 0", err_cnt); end
    checks++; if (err_cnt4 !== 4'd0) begin errors++; $display("FAIL clear_wins4: got %0d want 0", err_cnt4); end
    for (int k = 2; k <= 22; k++) drive(16'h0, 16'h0, 16'h0);
    checks++; if (err_cnt !== 32'd2) begin errors++; $display("FAIL clear_after: got %0d want 2", err_cnt); end
  endtask

  task automatic test_saturation();
    drive(16'h007F, 16'h0, 16'h0);
    for (int k = 1; k <= 22; k++) begin
      drive(16'h0, 16'h0, 16'h0);
      if (k == 3) begin
        checks++; if (err_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_reach: got %h want F", err_cnt4); end
      end
    end
    checks++; if (err_cnt !== 32'd23) begin errors++; $display("FAIL sat_wide: got %0d want 23", err_cnt); end
    checks++; if (err_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_hold: got %h want F", err_cnt4); end
    repeat (10) drive(16'h0, 16'h0, 16'h0);
    checks++; if (err_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_hold2: got %h want F", err_cnt4); end
  endtask

  task automatic test_cke_freeze();
    bit bad;
    cke = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) clr_err = 1'b1;
      drive(16'h0, 16'h0, 16'h0);
      checks++; if (lane_err !== 16'h0) begin errors++; $display("FAIL freeze_err %0d: got %h want 0000", k, lane_err); end
      checks++; if (lane_lock !== 16'hFFFF) begin errors++; $display("FAIL freeze_lock %0d: got %h want FFFF", k, lane_lock); end
      if (k < 4) begin
        checks++; if (err_cnt !== 32'd23) begin errors++; $display("FAIL freeze_cnt %0d: got %0d want 23", k, err_cnt); end
      end
    end
    clr_err = 1'b0;
    checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL freeze_clr: got %0d want 0", err_cnt); end
    checks++; if (err_cnt4 !== 4'd0) begin errors++; $display("FAIL freeze_clr4: got %0d want 0", err_cnt4); end
    cke = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      drive(16'h0, 16'h0, 16'h0);
      if (lane_err !== 16'h0) bad = 1'b1;
    end
    checks++; if (bad || err_cnt !== 32'd0 || lane_lock !== 16'hFFFF) begin
      errors++; $display("FAIL freeze_resume: err_cnt %0d lane_lock %h want 0/FFFF", err_cnt, lane_lock);
    end
  endtask

  task automatic test_stuck_zero();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      drive(16'h0, 16'h0200, 16'h0);
      if (k == 95) begin
        checks++; if (lane_lock !== 16'hFDFF) begin errors++; $display("FAIL stuck_lock_96: got %h want FDFF", lane_lock); end
      end
    end
    checks++; if (lane_lock !== 16'hFDFF) begin errors++; $display("FAIL stuck_lock_end: got %h want FDFF", lane_lock); end
    checks++; if (all_lock !== 1'b0) begin errors++; $display("FAIL stuck_all_lock: got %b want 0", all_lock); end
  endtask

  initial begin
    rst = 1'b1; cke = 1'b1; clr_err = 1'b0; din = '0; eqn = EQN;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_unlock_relock();
    test_clear();
    test_saturation();
    test_cke_freeze();
    test_stuck_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
